// File: rtl/serial_pkg.sv
// Shared types and defaults for the serializer slice (queue -> serial link).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } serial_state_t;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned LEN_WIDTH_DEF  = 8;

endpackage

// File: rtl/serial_shift_reg.sv
// Load/shift register with bit counter; presents the current serial bit.
// SERIALIZADOR_PARITY_EN appends an even-parity bit after the data bits.
module serial_shift_reg
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                  clk_10KHz,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  bit_out,
  output logic                  last_bit
);

`ifdef SERIALIZADOR_PARITY_EN
  localparam int unsigned NBITS = DATA_WIDTH + 1;
`else
  localparam int unsigned NBITS = DATA_WIDTH;
`endif
  localparam int unsigned       CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NBITS - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  data_bit;

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= data_in;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign data_bit = (MSB_FIRST != 0) ? shreg[DATA_WIDTH-1] : shreg[0];
  assign last_bit = (bit_cnt == LAST_IDX);

`ifdef SERIALIZADOR_PARITY_EN
  logic parity;

  // Parity is captured at load because the data bits are shifted away.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset)     parity <= 1'b0;
    else if (load) parity <= ^data_in;
  end

  assign bit_out = last_bit ? parity : data_bit;
`else
  assign bit_out = data_bit;
`endif

endmodule

// File: rtl/serializador.sv
// Pulls bytes from the fila queue and shifts them out on a bit valid/ready link.
// Optional parity bit: define SERIALIZADOR_PARITY_EN.
module serializador
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                  clk_10KHz,
  input  logic                  reset,
  input  logic                  en_in,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  dequeue_out,
  input  logic                  ready_in,
  output logic                  serial_out,
  output logic                  valid_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [7:0]            count_out
);

  serial_state_t state_q, state_d;
  logic          start, consume;
  logic          dequeue_d, done_d;
  logic          cur_bit, last_bit;

  assign start   = en_in && (len_in != '0);
  assign consume = (state_q == SHIFT) && ready_in;

  serial_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shift (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .load      (dequeue_d),
    .shift     (consume),
    .data_in   (data_in),
    .bit_out   (cur_bit),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dequeue_out <= 1'b0;
      done_out    <= 1'b0;
      count_out   <= '0;
    end else begin
      state_q     <= state_d;
      dequeue_out <= dequeue_d;
      done_out    <= done_d;
      if (done_d) count_out <= count_out + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (consume && last_bit) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses are computed here and registered, so they appear the cycle after the edge.
  always_comb begin
    valid_out  = (state_q == SHIFT);
    busy_out   = (state_q == SHIFT);
    serial_out = valid_out && cur_bit;
    dequeue_d  = (state_q == IDLE) && start;
    done_d     = consume && last_bit;
  end

endmodule

// File: tb/tb_serializador.sv
// Directed self-checking bench for serializador (parity-aware via SERIALIZADOR_PARITY_EN).
`timescale 1ns/1ps
module tb_serializador;

`ifdef SERIALIZADOR_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int PERIOD = NB + 2;

  logic       clk_10KHz = 1'b0;
  logic       reset, en_in, ready_in;
  logic [7:0] len_in, data_in;
  logic       dequeue_out, serial_out, valid_out, busy_out, done_out;
  logic [7:0] count_out;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit auto_q = 1'b0;
  bit pend   = 1'b0;

  serializador #(
    .DATA_WIDTH (8),
    .LEN_WIDTH  (8),
    .MSB_FIRST  (1)
  ) dut (
    .clk_10KHz   (clk_10KHz),
    .reset       (reset),
    .en_in       (en_in),
    .len_in      (len_in),
    .data_in     (data_in),
    .dequeue_out (dequeue_out),
    .ready_in    (ready_in),
    .serial_out  (serial_out),
    .valid_out   (valid_out),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .count_out   (count_out)
  );

  always #5 clk_10KHz = ~clk_10KHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue model: the entry is popped on the edge that samples dequeue_out high.
  task automatic tick();
    @(posedge clk_10KHz);
    #1;
    cyc++;
    if (auto_q && pend && len_in != 8'd0) len_in = len_in - 8'd1;
    pend = dequeue_out;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b >= 8) return ^d;
    return d[7-b];
  endfunction

  task automatic run_byte(input logic [7:0] d, input int stall_at, input int stall_n,
                          input logic [7:0] exp_cnt);
    int deqs;
    data_in  = d;
    en_in    = 1'b1;
    ready_in = 1'b1;
    tick();
    deqs = 1;
    check("start_deq", dequeue_out, 1);
    for (int b = 0; b < NB; b++) begin
      if (b == stall_at) begin
        ready_in = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check("hold_bit", {valid_out, serial_out}, {1'b1, exp_bit(d, b)});
          tick();
          deqs += int'(dequeue_out);
        end
        ready_in = 1'b1;
      end
      check("bit", {busy_out, valid_out, serial_out}, {1'b1, 1'b1, exp_bit(d, b)});
      tick();
      if (b < NB - 1) deqs += int'(dequeue_out);
    end
    check("gap_valid", {valid_out, busy_out, serial_out}, 3'b000);
    check("gap_done", done_out, 1);
    check("byte_count", count_out, exp_cnt);
    check("one_deq", deqs, 1);
    en_in = 1'b0;
    tick();
    check("idle_done", {done_out, valid_out}, 2'b00);
  endtask

  initial begin
    int p[4];
    int np, dq, dn, guard;
    reset = 1'b1; en_in = 1'b0; ready_in = 1'b0; len_in = 8'd0; data_in = 8'd0;
    #3;
    check("reset_outs", {dequeue_out, serial_out, valid_out, busy_out, done_out}, 5'b0);
    check("reset_count", count_out, 0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_empty", {dequeue_out, valid_out}, 2'b00);

    // single byte A5, then backpressure on 3C
    auto_q = 1'b1;
    len_in = 8'd1;
    run_byte(8'hA5, -1, 0, 8'd1);
    check("len_popped", len_in, 0);
    len_in = 8'd1;
    run_byte(8'h3C, 2, 5, 8'd2);

    // reset mid-byte after 3 accepted bits
    auto_q = 1'b0;
    len_in = 8'd1; data_in = 8'hA5; en_in = 1'b1; ready_in = 1'b1;
    tick();
    repeat (3) tick();
    check("mid_valid", valid_out, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_outs", {dequeue_out, serial_out, valid_out, busy_out, done_out}, 5'b0);
    check("rst_mid_count", count_out, 0);
    len_in = 8'd0;
    tick();
    reset = 1'b0;
    tick();
    check("rel_no_deq", {dequeue_out, valid_out}, 2'b00);

    // back-to-back bytes draining a 3-entry queue
    auto_q = 1'b1;
    len_in = 8'd3; data_in = 8'h5A; en_in = 1'b1; ready_in = 1'b1;
    np = 0;
    for (int i = 0; i < 3 * PERIOD + 15; i++) begin
      tick();
      if (dequeue_out) begin
        if (np < 4) p[np] = cyc;
        np++;
      end
    end
    check("b2b_deqs", np, 3);
    check("b2b_gap1", p[1] - p[0], PERIOD);
    check("b2b_gap2", p[2] - p[1], PERIOD);
    check("b2b_empty", {valid_out, busy_out}, 2'b00);
    check("b2b_len", len_in, 0);
    check("b2b_count", count_out, 3);

    // en_in dropped mid-byte: byte completes, no new start
    len_in = 8'd2;
    tick();
    dq = int'(dequeue_out); dn = 0;
    repeat (3) tick();
    en_in = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      tick();
      dq += int'(dequeue_out);
      dn += int'(done_out);
    end
    check("dis_deqs", dq, 1);
    check("dis_dones", dn, 1);
    check("dis_count", count_out, 4);
    check("dis_idle", valid_out, 0);

    // counter wrap after 256 bytes
    auto_q = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    len_in = 8'hFF; en_in = 1'b1; ready_in = 1'b1;
    dn = 0; guard = 0;
    while (dn < 256 && guard < 256 * PERIOD + 20) begin
      tick();
      guard++;
      if (done_out) begin
        dn++;
        if (dn == 255) check("cnt_255", count_out, 8'd255);
        if (dn == 256) en_in = 1'b0;
      end
    end
    check("wrap_dones", dn, 256);
    check("wrap_count", count_out, 0);
    repeat (2) tick();
    check("wrap_hold", {count_out, valid_out}, 9'd0);

`ifdef SERIALIZADOR_PARITY_EN
    auto_q = 1'b1;
    len_in = 8'd1;
    run_byte(8'h07, -1, 0, 8'd1);
    len_in = 8'd1;
    run_byte(8'h03, -1, 0, 8'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
